fft_frame_serializer: RTL and testbench

- Output-side counterpart to the FFT parallel frame register.
- Accepts one complete N-point frame of 16-bit samples in parallel through a valid/ready handshake.
- Streams the frame out one sample per beat on a valid/ready sample interface.
- Output order is natural or bit-reversed, selected per frame, so FFT results leave the core in the order the downstream consumer needs.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_frame_serializer.sv | 104 ++++++++++
 tb/tb_fft_frame_serializer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, serializer state encoding and
// the index bit-reversal helper used by both reorder paths.
package fft_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int N_POINTS_DEF = 64;
  localparam int LOG2_N_DEF   = 6;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_e;

  // Reverse the low 'width' bits of idx; upper bits return as zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] idx,
    input int          width
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r[5'(width - 1 - i)] = idx[5'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_serializer.sv
// Parallel FFT frame in (valid/ready), one sample per beat out (valid/ready),
// natural or bit-reversed order chosen per frame.
// Ports:
//   clk, rst (async, active-low), flush_i (sync abort)
//   frame_i/frame_valid_i/bitrev_en_i/frame_ready_o : frame input side
//   sample_o/sample_idx_o/sample_last_o/sample_valid_o/sample_ready_i :
//     sample output side
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int LOG2_N   = LOG2_N_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [N_POINTS*SAMPLE_W-1:0] frame_i,
  input  logic                         frame_valid_i,
  input  logic                         bitrev_en_i,
  output logic                         frame_ready_o,
  output logic [SAMPLE_W-1:0]          sample_o,
  output logic [LOG2_N-1:0]            sample_idx_o,
  output logic                         sample_last_o,
  output logic                         sample_valid_o,
  input  logic                         sample_ready_i
);

  ser_state_e                   state_q, state_d;
  logic [N_POINTS*SAMPLE_W-1:0] frame_q, frame_d;
  logic [LOG2_N-1:0]            cnt_q, cnt_d;
  logic                         rev_q, rev_d;

  logic                         streaming;
  logic                         last;
  logic                         beat;
  logic                         accept;
  logic [LOG2_N-1:0]            idx;
  logic [31:0]                  rev_idx;
  logic                         unused_rev;
  logic [SAMPLE_W-1:0]          words [N_POINTS];

  for (genvar k = 0; k < N_POINTS; k++) begin : g_word
    assign words[k] = frame_q[SAMPLE_W*k +: SAMPLE_W];
  end

  assign rev_idx    = bitrev({{(32-LOG2_N){1'b0}}, cnt_q}, LOG2_N);
  assign unused_rev = ^rev_idx[31:LOG2_N];
  assign idx        = rev_q ? rev_idx[LOG2_N-1:0] : cnt_q;

  assign streaming = (state_q == STREAM);
  assign last      = streaming && (cnt_q == LOG2_N'(N_POINTS - 1));
  assign beat      = streaming && sample_ready_i;

  // Ready during the last beat lets the next frame load with no bubble;
  // this makes frame_ready_o combinational on sample_ready_i.
  assign frame_ready_o = rst && !flush_i &&
                         (!streaming || (last && sample_ready_i));
  assign accept        = frame_valid_i && frame_ready_o;

  assign sample_valid_o = streaming;
  assign sample_last_o  = last;
  assign sample_idx_o   = streaming ? idx : '0;
  assign sample_o       = streaming ? words[idx] : '0;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    rev_d   = rev_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      rev_d   = 1'b0;
    end else if (accept) begin
      state_d = STREAM;
      frame_d = frame_i;
      cnt_d   = '0;
      rev_d   = bitrev_en_i;
    end else if (beat) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + LOG2_N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      rev_q   <= rev_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Directed bench for fft_frame_serializer: natural and bit-reversed
// order, backpressure, back-to-back frames, flush and async reset.
module tb_fft_frame_serializer;

  localparam int N = 64;
  localparam int W = 16;
  localparam int L = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush_i;
  logic [N*W-1:0] frame_i;
  logic           frame_valid_i;
  logic           bitrev_en_i;
  logic           frame_ready_o;
  logic [W-1:0]   sample_o;
  logic [L-1:0]   sample_idx_o;
  logic           sample_last_o;
  logic           sample_valid_o;
  logic           sample_ready_i;

  int total = 0;
  int bad   = 0;

  fft_frame_serializer #(
    .N_POINTS(N),
    .LOG2_N  (L),
    .SAMPLE_W(W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .bitrev_en_i   (bitrev_en_i),
    .frame_ready_o (frame_ready_o),
    .sample_o      (sample_o),
    .sample_idx_o  (sample_idx_o),
    .sample_last_o (sample_last_o),
    .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] mk(input logic [W-1:0] base);
    logic [N*W-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[W*k +: W] = base + W'(k);
    return f;
  endfunction

  function automatic logic [L-1:0] brev(input logic [L-1:0] v);
    logic [L-1:0] r;
    r = {<<{v}};
    return r;
  endfunction

  task automatic send_frame(input logic [W-1:0] base, input logic rev);
    @(negedge clk);
    frame_i        = mk(base);
    frame_valid_i  = 1'b1;
    bitrev_en_i    = rev;
    sample_ready_i = 1'b1;
    #1;
    total++;
    if (frame_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready got=%b exp=1", frame_ready_o);
    end
    @(posedge clk);
    #1;
    frame_valid_i = 1'b0;
    bitrev_en_i   = ~rev;
  endtask

  task automatic run_stream(
    input logic [W-1:0] base,
    input logic         rev,
    input int           stall_at,
    input int           stall_len,
    input int           stop
  );
    int           b;
    int           st;
    int           cyc;
    logic [L-1:0] ei;
    logic [L-1:0] tab [5];
    tab = '{6'd0, 6'd32, 6'd16, 6'd48, 6'd8};
    b   = 0;
    st  = 0;
    cyc = 0;
    while (b < stop && cyc < 300) begin
      @(negedge clk);
      cyc++;
      sample_ready_i = !(b == stall_at && st < stall_len);
      #1;
      ei = rev ? brev(L'(b)) : L'(b);
      if (rev && b < 5) ei = tab[b];
      total++;
      if (sample_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL valid beat=%0d got=%b exp=1", b, sample_valid_o);
      end
      total++;
      if (sample_idx_o !== ei) begin
        bad++;
        $display("FAIL idx beat=%0d got=%0d exp=%0d", b, sample_idx_o, ei);
      end
      total++;
      if (sample_o !== base + W'(ei)) begin
        bad++;
        $display("FAIL sample beat=%0d got=%h exp=%h",
                 b, sample_o, base + W'(ei));
      end
      total++;
      if (sample_last_o !== (b == N - 1)) begin
        bad++;
        $display("FAIL last beat=%0d got=%b exp=%b",
                 b, sample_last_o, (b == N - 1));
      end
      if (sample_ready_i) begin
        total++;
        if (frame_ready_o !== (b == N - 1)) begin
          bad++;
          $display("FAIL ready beat=%0d got=%b exp=%b",
                   b, frame_ready_o, (b == N - 1));
        end
        b++;
      end else begin
        st++;
      end
    end
    total++;
    if (b != stop) begin
      bad++;
      $display("FAIL beat_count got=%0d exp=%0d", b, stop);
    end
    if (stall_len > 0) begin
      total++;
      if (st != stall_len) begin
        bad++;
        $display("FAIL stall_cycles got=%0d exp=%0d", st, stall_len);
      end
    end
    sample_ready_i = 1'b1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    #1;
    total++;
    if (sample_valid_o !== 1'b0 || sample_idx_o !== '0 ||
        sample_o !== '0 || sample_last_o !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_out got=v%b i%0d s%h l%b exp=0", tag,
               sample_valid_o, sample_idx_o, sample_o, sample_last_o);
    end
    total++;
    if (frame_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_ready got=%b exp=1", tag, frame_ready_o);
    end
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    flush_i        = 1'b0;
    frame_i        = '0;
    frame_valid_i  = 1'b0;
    bitrev_en_i    = 1'b0;
    sample_ready_i = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (frame_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=0", frame_ready_o);
    end
    total++;
    if (sample_valid_o !== 1'b0 || sample_last_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b/%b exp=0/0",
               sample_valid_o, sample_last_o);
    end
    total++;
    if (sample_o !== '0 || sample_idx_o !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h/%0d exp=0/0", sample_o, sample_idx_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    expect_idle("post_rst");
  endtask

  task automatic test_natural;
    send_frame(16'h1000, 1'b0);
    run_stream(16'h1000, 1'b0, -1, 0, N);
    expect_idle("natural_end");
  endtask

  task automatic test_bitrev;
    send_frame(16'h1000, 1'b1);
    run_stream(16'h1000, 1'b1, -1, 0, N);
    expect_idle("bitrev_end");
  endtask

  task automatic test_backpressure;
    send_frame(16'h1000, 1'b0);
    run_stream(16'h1000, 1'b0, 5, 3, N);
    expect_idle("bp_end");
  endtask

  task automatic test_back_to_back;
    send_frame(16'h1000, 1'b0);
    frame_i       = mk(16'h2000);
    frame_valid_i = 1'b1;
    bitrev_en_i   = 1'b0;
    run_stream(16'h1000, 1'b0, -1, 0, N);
    @(posedge clk);
    #1;
    frame_valid_i = 1'b0;
    run_stream(16'h2000, 1'b0, -1, 0, N);
    expect_idle("b2b_end");
  endtask

  task automatic test_flush;
    send_frame(16'h3000, 1'b0);
    run_stream(16'h3000, 1'b0, -1, 0, 10);
    @(negedge clk);
    flush_i       = 1'b1;
    frame_i       = mk(16'h4000);
    frame_valid_i = 1'b1;
    bitrev_en_i   = 1'b0;
    #1;
    total++;
    if (sample_idx_o !== 6'd10 || sample_o !== 16'h300A) begin
      bad++;
      $display("FAIL flush_beat got=%0d/%h exp=10/300a",
               sample_idx_o, sample_o);
    end
    total++;
    if (frame_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready got=%b exp=0", frame_ready_o);
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (sample_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid got=%b exp=0", sample_valid_o);
    end
    total++;
    if (frame_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_reaccept got=%b exp=1", frame_ready_o);
    end
    @(posedge clk);
    #1;
    frame_valid_i = 1'b0;
    run_stream(16'h4000, 1'b0, -1, 0, N);
    expect_idle("flush_end");
  endtask

  task automatic test_async_reset;
    send_frame(16'h5000, 1'b0);
    run_stream(16'h5000, 1'b0, -1, 0, 20);
    @(posedge clk);
    #2;
    total++;
    if (sample_idx_o !== 6'd20 || sample_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre got=%0d/%b exp=20/1",
               sample_idx_o, sample_valid_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if (sample_valid_o !== 1'b0 || sample_idx_o !== '0 ||
        sample_o !== '0 || frame_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL arst_drop got=v%b i%0d s%h r%b exp=0",
               sample_valid_o, sample_idx_o, sample_o, frame_ready_o);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) expect_idle("arst_after");
    send_frame(16'h1000, 1'b0);
    run_stream(16'h1000, 1'b0, -1, 0, N);
    expect_idle("arst_end");
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
